// File: rtl/exec_pkg.sv
// Shared opcode/state types and default sizes for exec_unit.
// Divide support is compiled in only when EXEC_UNIT_DIV_EN is defined.
package exec_pkg;

   localparam int unsigned WIDTH_DEF   = 16;
   localparam int unsigned RADDR_W_DEF = 5;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_SLT = 4'd5,
      OP_SLL = 4'd6,
      OP_SRL = 4'd7,
      OP_MUL = 4'd8,
      OP_DIV = 4'd9,
      OP_REM = 4'd10
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Opcodes that go through the multi-cycle datapath.
   function automatic logic is_iter_op(input logic [3:0] op);
`ifdef EXEC_UNIT_DIV_EN
      return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
`else
      return op == OP_MUL;
`endif
   endfunction

   function automatic logic is_legal_op(input logic [3:0] op);
`ifdef EXEC_UNIT_DIV_EN
      return op <= OP_REM;
`else
      return op <= OP_MUL;
`endif
   endfunction

endpackage

// File: rtl/iter_muldiv.sv
// WIDTH-iteration shift-add multiplier and, with EXEC_UNIT_DIV_EN, restoring divider.
// The first iteration runs on the start edge so done pulses after exactly WIDTH edges.
module iter_muldiv
   import exec_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef EXEC_UNIT_DIV_EN
   input  logic             div_mode,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
`ifdef EXEC_UNIT_DIV_EN
   output logic [WIDTH-1:0] quot,
`endif
   output logic [WIDTH-1:0] acc
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [WIDTH-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d;
   logic [WIDTH-1:0] acc_s, x_s, y_s, acc_n, x_n, y_n;
`ifdef EXEC_UNIT_DIV_EN
   logic             div_q, div_d, div_s;
   logic [WIDTH:0]   rem_t;
   logic             fits;
`endif

   // One iteration step; x is multiplicand/divisor, y is multiplier/dividend-quotient.
   always_comb begin
      acc_s = start ? '0 : acc_q;
`ifdef EXEC_UNIT_DIV_EN
      div_s = start ? div_mode : div_q;
      x_s   = start ? (div_mode ? b : a) : x_q;
      y_s   = start ? (div_mode ? a : b) : y_q;
`else
      x_s   = start ? a : x_q;
      y_s   = start ? b : y_q;
`endif
      acc_n = y_s[0] ? acc_s + x_s : acc_s;
      x_n   = x_s << 1;
      y_n   = y_s >> 1;
`ifdef EXEC_UNIT_DIV_EN
      rem_t = {acc_s, y_s[WIDTH-1]};
      fits  = rem_t >= {1'b0, x_s};
      if (div_s) begin
         x_n   = x_s;
         y_n   = {y_s[WIDTH-2:0], fits};
         acc_n = fits ? WIDTH'(rem_t - {1'b0, x_s}) : rem_t[WIDTH-1:0];
      end
`endif
   end

   always_comb begin
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done_d = 1'b0;
      acc_d  = acc_q;
      x_d    = x_q;
      y_d    = y_q;
`ifdef EXEC_UNIT_DIV_EN
      div_d  = div_q;
`endif
      if (start || busy_q) begin
         acc_d = acc_n;
         x_d   = x_n;
         y_d   = y_n;
      end
      if (start) begin
         cnt_d  = CNT_W'(1);
         busy_d = 1'b1;
`ifdef EXEC_UNIT_DIV_EN
         div_d  = div_mode;
`endif
      end else if (busy_q) begin
         if (cnt_q == CNT_W'(WIDTH - 1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            cnt_d  = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         acc_q  <= '0;
         x_q    <= '0;
         y_q    <= '0;
`ifdef EXEC_UNIT_DIV_EN
         div_q  <= 1'b0;
`endif
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         done_q <= done_d;
         acc_q  <= acc_d;
         x_q    <= x_d;
         y_q    <= y_d;
`ifdef EXEC_UNIT_DIV_EN
         div_q  <= div_d;
`endif
      end
   end

   assign done = done_q;
   assign acc  = acc_q;
`ifdef EXEC_UNIT_DIV_EN
   assign quot = y_q;
`endif

endmodule

// File: rtl/exec_unit.sv
// Execution unit: handshake FSM, single-cycle ALU, iterative mul/div via iter_muldiv.
// Define EXEC_UNIT_DIV_EN to enable DIV/REM; otherwise they decode as illegal.
module exec_unit
   import exec_pkg::*;
#(
   parameter int unsigned WIDTH   = WIDTH_DEF,
   parameter int unsigned RADDR_W = RADDR_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [RADDR_W-1:0] rd_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic [RADDR_W-1:0] rd_out,
   output logic               dz,
   output logic               illegal
);

   state_e               state_q, state_d;
   logic                 in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic                 illegal_q, illegal_d;
   logic [WIDTH-1:0]     result_q, result_d, alu_res;
   logic [RADDR_W-1:0]   rd_q, rd_d;
   logic                 md_start, md_done;
   logic [WIDTH-1:0]     md_acc;
`ifdef EXEC_UNIT_DIV_EN
   logic                 dz_q, dz_d, sel_quot_q, sel_quot_d;
   logic [WIDTH-1:0]     md_quot;
`endif

   always_comb begin
      alu_res = '0;
      case (op)
         OP_ADD:  alu_res = a + b;
         OP_SUB:  alu_res = a - b;
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
         OP_SLL:  alu_res = a << b[3:0];
         OP_SRL:  alu_res = a >> b[3:0];
         default: alu_res = '0;
      endcase
   end

   // Inputs are only looked at in IDLE; results hold in DONE until the handshake.
   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      rd_d        = rd_q;
      illegal_d   = illegal_q;
      md_start    = 1'b0;
`ifdef EXEC_UNIT_DIV_EN
      dz_d        = dz_q;
      sel_quot_d  = sel_quot_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               rd_d       = rd_in;
               in_ready_d = 1'b0;
               illegal_d  = !is_legal_op(op);
`ifdef EXEC_UNIT_DIV_EN
               dz_d       = 1'b0;
`endif
               if (is_iter_op(op)) begin
                  md_start = 1'b1;
                  state_d  = CALC;
`ifdef EXEC_UNIT_DIV_EN
                  dz_d       = ((op == OP_DIV) || (op == OP_REM)) && (b == '0);
                  sel_quot_d = (op == OP_DIV);
`endif
               end else begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  result_d    = is_legal_op(op) ? alu_res : '0;
               end
            end
         end
         CALC: begin
            if (md_done) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
`ifdef EXEC_UNIT_DIV_EN
               result_d    = sel_quot_q ? md_quot : md_acc;
`else
               result_d    = md_acc;
`endif
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         rd_q        <= '0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         rd_q        <= rd_d;
         illegal_q   <= illegal_d;
      end
   end

`ifdef EXEC_UNIT_DIV_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dz_q       <= 1'b0;
         sel_quot_q <= 1'b0;
      end else begin
         dz_q       <= dz_d;
         sel_quot_q <= sel_quot_d;
      end
   end
   assign dz = dz_q;
`else
   assign dz = 1'b0;
`endif

   iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk      (clk),
      .rst      (rst),
      .start    (md_start),
`ifdef EXEC_UNIT_DIV_EN
      .div_mode ((op == OP_DIV) || (op == OP_REM)),
      .quot     (md_quot),
`endif
      .a        (a),
      .b        (b),
      .done     (md_done),
      .acc      (md_acc)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign rd_out    = rd_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: directed cases then random operations against an arithmetic reference model.
module tb_exec_unit;

   localparam int unsigned W        = 16;
   localparam int unsigned RW       = 5;
   localparam int          LONG_LAT = W + 1;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_ready, out_valid, out_ready, dz, illegal;
   logic [3:0]    op;
   logic [W-1:0]  a, b, result;
   logic [RW-1:0] rd_in, rd_out;
   int            tests = 0;
   int            fails = 0;

   always #5 clk = ~clk;

   exec_unit #(.WIDTH(W), .RADDR_W(RW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .rd_in     (rd_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .rd_out    (rd_out),
      .dz        (dz),
      .illegal   (illegal)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference behaviour straight from the opcode table.
   function automatic void model(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                                 output logic [W-1:0] r, output logic edz, output logic eill,
                                 output int lat);
      int unsigned ua, ub;
      ua = va; ub = vb;
      r = '0; edz = 1'b0; eill = 1'b0; lat = 1;
      case (o)
         4'd0: r = W'(ua + ub);
         4'd1: r = W'(ua - ub);
         4'd2: r = va & vb;
         4'd3: r = va | vb;
         4'd4: r = va ^ vb;
         4'd5: r = ($signed(va) < $signed(vb)) ? W'(1) : W'(0);
         4'd6: r = W'(ua << vb[3:0]);
         4'd7: r = W'(ua >> vb[3:0]);
         4'd8: begin r = W'(ua * ub); lat = LONG_LAT; end
`ifdef EXEC_UNIT_DIV_EN
         4'd9, 4'd10: begin
            lat = LONG_LAT;
            if (ub == 0) begin
               edz = 1'b1;
               r   = (o == 4'd9) ? '1 : va;
            end else begin
               r = (o == 4'd9) ? W'(ua / ub) : W'(ua % ub);
            end
         end
`endif
         default: eill = 1'b1;
      endcase
   endfunction

   task automatic junk_inputs();
      in_valid = 1'b1;
      op       = 4'($urandom);
      a        = W'($urandom);
      b        = W'($urandom);
      rd_in    = RW'($urandom);
   endtask

   task automatic run_op(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [RW-1:0] vr, input int hold);
      logic [W-1:0] er;
      logic         edz, eill, rdy_seen;
      int           elat, lat, waitc;
      model(o, va, vb, er, edz, eill, elat);
      waitc = 0;
      while (in_ready !== 1'b1 && waitc < 40) begin tick(); waitc++; end
      check("ready_before_accept", 32'(in_ready), 32'd1);
      in_valid = 1'b1; op = o; a = va; b = vb; rd_in = vr; out_ready = 1'b0;
      tick();
      lat = 1; rdy_seen = 1'b0;
      while (out_valid !== 1'b1 && lat < 40) begin
         if (in_ready !== 1'b0) rdy_seen = 1'b1;
         junk_inputs();
         out_ready = 1'($urandom);
         tick();
         lat++;
      end
      out_ready = 1'b0;
      check("latency", 32'(lat), 32'(elat));
      check("out_valid", 32'(out_valid), 32'd1);
      check("result", 32'(result), 32'(er));
      check("rd_out", 32'(rd_out), 32'(vr));
      check("dz", 32'(dz), 32'(edz));
      check("illegal", 32'(illegal), 32'(eill));
      check("ready_low_while_busy", {30'd0, in_ready, rdy_seen}, 32'd0);
      for (int k = 0; k < hold; k++) begin
         junk_inputs();
         tick();
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_result", 32'(result), 32'(er));
         check("hold_rd", 32'(rd_out), 32'(vr));
         check("hold_ready", 32'(in_ready), 32'd0);
      end
      junk_inputs();
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      check("post_valid", 32'(out_valid), 32'd0);
      check("post_ready_no_accept", 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      op = '0; a = '0; b = '0; rd_in = '0;
      repeat (2) tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_rd_out", 32'(rd_out), 32'd0);
      check("rst_flags", {30'd0, dz, illegal}, 32'd0);
      rst = 1'b0;
      #1;
      check("rst_release_ready", 32'(in_ready), 32'd1);

      run_op(4'd0, 16'h7FFF, 16'h0001, 5'd3, 0);
      run_op(4'd8, 16'h0123, 16'h0010, 5'd5, 1);
      run_op(4'd9, 16'd100, 16'd7, 5'd6, 0);
      run_op(4'd10, 16'd100, 16'd7, 5'd7, 0);
      run_op(4'd9, 16'h1234, 16'h0000, 5'd8, 0);
      run_op(4'd10, 16'h1234, 16'h0000, 5'd9, 0);
      run_op(4'd1, 16'h0000, 16'h0001, 5'd10, 5);
      run_op(4'd12, 16'hABCD, 16'h1111, 5'd11, 0);
      run_op(4'd5, 16'h8000, 16'h0001, 5'd12, 0);
      run_op(4'd6, 16'h0001, 16'h001F, 5'd13, 0);
      run_op(4'd7, 16'h8000, 16'h000F, 5'd14, 0);
      run_op(4'd8, 16'hFFFF, 16'hFFFF, 5'd15, 0);

      // Reset in the 8th CALC cycle of a multiply discards it.
      in_valid = 1'b1; op = 4'd8; a = 16'h0123; b = 16'h0010; rd_in = 5'd21;
      tick();
      in_valid = 1'b0;
      repeat (7) tick();
      check("mid_calc_busy", {30'd0, out_valid, in_ready}, 32'd0);
      rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(out_valid), 32'd0);
      check("async_rst_result", 32'(result), 32'd0);
      check("async_rst_rd", 32'(rd_out), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("post_rst_ready", 32'(in_ready), 32'd1);
      run_op(4'd0, 16'd2, 16'd3, 5'd4, 0);

      for (int i = 0; i < 40; i++) begin
         logic [3:0]   ro;
         logic [W-1:0] ra, rb;
         ro = 4'($urandom_range(0, 15));
         ra = W'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         run_op(ro, ra, rb, RW'($urandom), int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
